// File: rtl/dmem_pkg.sv
// ============================================================================
// Module : dmem_pkg
// Brief  : RV32I load/store width codes and controller state encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/dmem_lane_fmt.sv
// ============================================================================
// Module : dmem_lane_fmt
// Brief  : Lane extract/extend for loads, byte-merge for stores, access check.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] word_i,
  output logic [31:0] load_o,
  output logic [31:0] store_o,
  output logic        err_o
);

  logic [31:0] shifted;
  logic [31:0] wrep;
  logic [3:0]  be;

  assign shifted = word_i >> {offset_i, 3'b000};

  always_comb begin
    load_o = '0;
    wrep   = '0;
    be     = '0;
    err_o  = 1'b0;
    case (funct3_i)
      F3_B: begin
        load_o = {{24{shifted[7]}}, shifted[7:0]};
        wrep   = {4{wdata_i[7:0]}};
        be     = 4'b0001 << offset_i;
      end
      F3_H: begin
        load_o = {{16{shifted[15]}}, shifted[15:0]};
        wrep   = {2{wdata_i[15:0]}};
        be     = 4'b0011 << offset_i;
        err_o  = offset_i[0];
      end
      F3_W: begin
        load_o = word_i;
        wrep   = wdata_i;
        be     = 4'b1111;
        err_o  = |offset_i;
      end
      // Unsigned widths exist only for loads
      F3_BU: begin
        load_o = {24'd0, shifted[7:0]};
        err_o  = we_i;
      end
      F3_HU: begin
        load_o = {16'd0, shifted[15:0]};
        err_o  = we_i | offset_i[0];
      end
      default: err_o = 1'b1;
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign store_o[8*i +: 8] = be[i] ? wrep[8*i +: 8] : word_i[8*i +: 8];
  end

endmodule

`default_nettype wire

// File: rtl/data_memory_ctrl.sv
// ============================================================================
// Module : data_memory_ctrl
// Brief  : Word RAM with RV32I byte/half/word access, wait states, req/ready.
//          Define DMEM_MMIO_EN to map an output register at MMIO_ADDR.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2,
  parameter string       INIT_FILE = "",
  parameter logic [31:0] MMIO_ADDR = 32'hFFFF_FFF0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
`ifdef DMEM_MMIO_EN
  ,
  output logic [31:0] mmio_out
`endif
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [3:0]  LAT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [DEPTH];

  logic [AW-1:0] idx;
  logic          resp;
  logic          is_mmio;
  logic [31:0]   cur_word;
  logic [31:0]   fmt_load;
  logic [31:0]   fmt_store;
  logic          fmt_err;

  assign idx  = addr_q[AW+1:2];
  // A reset landing on the response cycle suppresses the pulse and the commit
  assign resp = (state_q == ST_RESP) && !rst;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          cnt_d   = LAT_LOAD;
          state_d = (LATENCY == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == ST_IDLE && req) begin
        we_q    <= we;
        f3_q    <= funct3;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
    end
  end

  dmem_lane_fmt u_fmt (
    .we_i     (we_q),
    .funct3_i (f3_q),
    .offset_i (addr_q[1:0]),
    .wdata_i  (wdata_q),
    .word_i   (cur_word),
    .load_o   (fmt_load),
    .store_o  (fmt_store),
    .err_o    (fmt_err)
  );

  always_ff @(posedge clk) begin
    if (resp && we_q && !fmt_err && !is_mmio) begin
      mem[idx] <= fmt_store;
    end
  end

`ifdef DMEM_MMIO_EN
  logic [31:0] mmio_q;

  assign is_mmio  = (addr_q[31:2] == MMIO_ADDR[31:2]);
  assign cur_word = is_mmio ? mmio_q : mem[idx];
  assign mmio_out = mmio_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mmio_q <= '0;
    end else if (resp && we_q && !fmt_err && is_mmio) begin
      mmio_q <= fmt_store;
    end
  end
`else
  logic unused_bits;

  assign is_mmio     = 1'b0;
  assign cur_word    = mem[idx];
  assign unused_bits = ^{addr_q[31:AW+2], MMIO_ADDR};
`endif

  assign ready = resp;
  assign err   = resp & fmt_err;
  assign rdata = (resp && !fmt_err && !we_q) ? fmt_load : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_data_memory_ctrl.sv
// ============================================================================
// Module : tb_data_memory_ctrl
// Brief  : Self-checking bench for data_memory_ctrl (LATENCY=2 and LATENCY=0).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_data_memory_ctrl;

  localparam int          LAT  = 2;
  localparam int          DEP  = 1024;
  localparam logic [31:0] MMIO = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata;
  logic        ready, err;
  logic [31:0] mmio_out;

  logic        r0, we0;
  logic [2:0]  f30;
  logic [31:0] a0, wd0, rd0;
  logic        rdy0, e0;
  logic [31:0] mmio0;

  always #5 clk = ~clk;

  data_memory_ctrl #(.DEPTH(DEP), .LATENCY(LAT), .INIT_FILE(""), .MMIO_ADDR(MMIO)) u_dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ready(ready), .err(err)
`ifdef DMEM_MMIO_EN
    , .mmio_out(mmio_out)
`endif
  );

  data_memory_ctrl #(.DEPTH(64), .LATENCY(0), .INIT_FILE(""), .MMIO_ADDR(MMIO)) u_dut0 (
    .clk(clk), .rst(rst), .req(r0), .we(we0), .funct3(f30), .addr(a0),
    .wdata(wd0), .rdata(rd0), .ready(rdy0), .err(e0)
`ifdef DMEM_MMIO_EN
    , .mmio_out(mmio0)
`endif
  );

`ifndef DMEM_MMIO_EN
  assign mmio_out = 32'd0;
  assign mmio0    = 32'd0;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // ---------------- behavioural model ----------------
  logic [31:0] mm [DEP];
  logic [31:0] mmio_m = 32'd0;

  function automatic bit m_is_mmio(logic [31:0] a);
`ifdef DMEM_MMIO_EN
    return (a >> 2) == (MMIO >> 2);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_word(logic [31:0] a);
    if (m_is_mmio(a)) return mmio_m;
    return mm[(a >> 2) % DEP];
  endfunction

  function automatic bit m_err(bit w, logic [2:0] f3, logic [31:0] a);
    int size;
    bit legal;
    size  = 1 << f3[1:0];
    legal = w ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    return !legal || ((a % size) != 0);
  endfunction

  bit          pending = 1'b0;
  int          exp_cyc;
  logic [31:0] exp_rdata;
  logic        exp_err;
  bit          cmp_en = 1'b0;

  // Compute the response and apply any store to the model at issue time;
  // accesses are strictly sequential so this matches commit order.
  task automatic model_issue(bit w, logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
    logic [31:0] word, val, mask;
    int size, off;
    word = m_word(a);
    size = 1 << f3[1:0];
    off  = a % 4;
    exp_err   = m_err(w, f3, a);
    exp_rdata = 32'd0;
    if (!exp_err && !w) begin
      val  = word >> (8 * off);
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      val  = val & mask;
      if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~mask;
      exp_rdata = val;
    end
    if (!exp_err && w) begin
      for (int i = 0; i < size; i++) word[8*(off+i) +: 8] = wd[8*i +: 8];
      if (m_is_mmio(a)) mmio_m = word;
      else              mm[(a >> 2) % DEP] = word;
    end
  endtask

  always @(negedge clk) begin
    bit er;
    if (cmp_en) begin
      er = pending && (cyc == exp_cyc);
      chk("ready", {31'd0, ready}, {31'd0, er});
      chk("err",   {31'd0, err},   {31'd0, er ? exp_err : 1'b0});
      chk("rdata", rdata, er ? exp_rdata : 32'd0);
      if (er) pending = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic access(bit w, logic [2:0] f3, logic [31:0] a, logic [31:0] wd, bit tog,
                        output logic [31:0] rd, output logic e);
    int  issue;
    bit  seen;
    @(posedge clk); #1;
    req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
    model_issue(w, f3, a, wd);
    issue   = cyc;
    exp_cyc = cyc + LAT + 1;
    pending = 1'b1;
    @(posedge clk); #1;
    req = tog; we = ~w; funct3 = 3'b111; addr = ~a; wdata = ~wd;
    if (tog) begin
      repeat (LAT) @(posedge clk);
      #1 req = 1'b0;
    end
    seen = 1'b0;
    rd   = 32'd0;
    e    = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (ready) begin
        seen = 1'b1;
        rd   = rdata;
        e    = err;
        chk("latency", cyc - issue, LAT + 1);
      end
    end
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: no ready for addr %h, required within 40 cycles", a);
      pending = 1'b0;
    end
  endtask

  task automatic access0(bit w, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                         output logic [31:0] rd);
    @(posedge clk); #1;
    r0 = 1'b1; we0 = w; f30 = f3; a0 = a; wd0 = wd;
    @(negedge clk);
    chk("l0_ready_idle", {31'd0, rdy0}, 32'd0);
    @(posedge clk); #1;
    r0 = 1'b0; a0 = ~a; wd0 = ~wd;
    @(negedge clk);
    chk("l0_ready", {31'd0, rdy0}, 32'd1);
    chk("l0_err",   {31'd0, e0},   32'd0);
    rd = rd0;
  endtask

  logic [31:0] rv;
  logic        ev;

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    r0 = 1'b0; we0 = 1'b0; f30 = 3'd0; a0 = 32'd0; wd0 = 32'd0;
    for (int i = 0; i < DEP; i++) mm[i] = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_err",   {31'd0, err},   32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mmio",  mmio_out, 32'd0);
    cmp_en = 1'b1;

    // basic word store / load
    access(1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0, rv, ev);
    access(0, 3'b010, 32'h10, 32'h0, 0, rv, ev);
    chk("lw10", rv, 32'hDEAD_BEEF);
    chk("lw10_err", {31'd0, ev}, 32'd0);

    // sub-word loads and byte store
    access(0, 3'b000, 32'h13, 32'h0, 0, rv, ev);  chk("lb13",  rv, 32'hFFFF_FFDE);
    access(0, 3'b100, 32'h13, 32'h0, 0, rv, ev);  chk("lbu13", rv, 32'h0000_00DE);
    access(0, 3'b001, 32'h12, 32'h0, 0, rv, ev);  chk("lh12",  rv, 32'hFFFF_DEAD);
    access(0, 3'b101, 32'h10, 32'h0, 0, rv, ev);  chk("lhu10", rv, 32'h0000_BEEF);
    access(1, 3'b000, 32'h11, 32'h55, 0, rv, ev);
    access(0, 3'b010, 32'h10, 32'h0, 0, rv, ev);  chk("lw10_sb", rv, 32'hDEAD_55EF);

    // errors
    access(0, 3'b010, 32'h12, 32'h0, 0, rv, ev);
    chk("lw12_err", {31'd0, ev}, 32'd1);
    chk("lw12_rd",  rv, 32'd0);
    access(1, 3'b001, 32'h11, 32'h9999, 0, rv, ev);
    chk("sh11_err", {31'd0, ev}, 32'd1);
    access(0, 3'b010, 32'h10, 32'h0, 0, rv, ev);  chk("lw10_keep", rv, 32'hDEAD_55EF);
    access(0, 3'b011, 32'h10, 32'h0, 0, rv, ev);  chk("ld011_err", {31'd0, ev}, 32'd1);
    access(1, 3'b100, 32'h10, 32'h1, 0, rv, ev);  chk("sbu_err",   {31'd0, ev}, 32'd1);
    access(1, 3'b001, 32'h12, 32'hCAFE, 0, rv, ev);
    access(0, 3'b010, 32'h10, 32'h0, 0, rv, ev);  chk("lw10_sh", rv, 32'hCAFE_55EF);

    // address wrap
    access(1, 3'b010, 32'h1000, 32'h1234, 0, rv, ev);
    access(0, 3'b010, 32'h0, 32'h0, 0, rv, ev);   chk("wrap", rv, 32'h0000_1234);

    // reset during WAIT drops the pending store
    access(1, 3'b010, 32'h20, 32'h1122_3344, 0, rv, ev);
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h20; wdata = 32'hFF;
    @(posedge clk); #1;
    req = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    access(0, 3'b010, 32'h20, 32'h0, 0, rv, ev);  chk("rst_drop", rv, 32'h1122_3344);

    // req held high during WAIT is ignored
    access(0, 3'b010, 32'h10, 32'h0, 1, rv, ev);  chk("tog_lw", rv, 32'hCAFE_55EF);
    repeat (4) @(negedge clk);

`ifdef DMEM_MMIO_EN
    access(1, 3'b010, 32'h0FF0, 32'h7777_7777, 0, rv, ev);
    access(1, 3'b010, MMIO, 32'hA5, 0, rv, ev);
    @(posedge clk); #1;
    chk("mmio_sw", mmio_out, 32'h0000_00A5);
    access(0, 3'b010, MMIO, 32'h0, 0, rv, ev);      chk("mmio_lw", rv, 32'h0000_00A5);
    access(0, 3'b010, 32'h0FF0, 32'h0, 0, rv, ev);  chk("mmio_alias", rv, 32'h7777_7777);
    access(1, 3'b000, MMIO + 1, 32'h3C, 0, rv, ev);
    @(posedge clk); #1;
    chk("mmio_sb", mmio_out, 32'h0000_3CA5);
`endif

    // zero-latency instance
    access0(1, 3'b010, 32'h40, 32'hCAFE_F00D, rv);
    access0(0, 3'b010, 32'h40, 32'h0, rv);        chk("l0_lw", rv, 32'hCAFE_F00D);
    access0(0, 3'b000, 32'h43, 32'h0, rv);        chk("l0_lb", rv, 32'hFFFF_FFCA);
`ifdef DMEM_MMIO_EN
    access0(1, 3'b010, MMIO, 32'hA5, rv);
    @(posedge clk); #1;
    chk("l0_mmio", mmio0, 32'h0000_00A5);
`endif

    repeat (3) @(negedge clk);
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required end before 200000");
    $fatal(1);
  end

endmodule

`default_nettype wire
